// File: rtl/add_rc_ctrl.sv
// add_rc_ctrl: sequencer for an add-round-constant pass over 64 slices.
// Each slice takes three cycles: LOAD (input slice), XOR (feedback), WRITE.
// Build option: define ADD_RC_CTRL_ROUND_AUTO_EN to use an internal round
// counter for the LUT address instead of the externally supplied round_in.
module add_rc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       co,
  input  logic [4:0] round_in,
  input  logic       round_clr,
  output logic       ld,
  output logic       sel_in,
  output logic       inc_counter,
  output logic       counter_rst,
  output logic       write,
  output logic [4:0] address,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       round_last
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_LOAD  = 3'd2,
    S_XOR   = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [4:0] LAST_ROUND = 5'd23;

  state_t     state_r;
  state_t     state_nxt_s;
  logic       ld_r;
  logic       sel_in_r;
  logic       counter_rst_r;
  logic       write_r;
  logic       ready_r;
  logic       busy_r;
  logic       done_r;
  logic [4:0] addr_r;

  // Next-state selection; start is only looked at in IDLE and co only in WRITE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = S_INIT;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_INIT:  state_nxt_s = S_LOAD;
      S_LOAD:  state_nxt_s = S_XOR;
      S_XOR:   state_nxt_s = S_WRITE;
      S_WRITE: begin
        if (co) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_LOAD;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register with Moore outputs pre-decoded from the next state so they
  // line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      ld_r          <= 1'b0;
      sel_in_r      <= 1'b0;
      counter_rst_r <= 1'b0;
      write_r       <= 1'b0;
      ready_r       <= 1'b1;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      ld_r          <= (state_nxt_s == S_LOAD) || (state_nxt_s == S_XOR);
      sel_in_r      <= (state_nxt_s == S_XOR);
      counter_rst_r <= (state_nxt_s == S_INIT);
      write_r       <= (state_nxt_s == S_WRITE);
      ready_r       <= (state_nxt_s == S_IDLE);
      busy_r        <= (state_nxt_s == S_INIT) || (state_nxt_s == S_LOAD) ||
                       (state_nxt_s == S_XOR)  || (state_nxt_s == S_WRITE);
      done_r        <= (state_nxt_s == S_DONE);
    end
  end

`ifdef ADD_RC_CTRL_ROUND_AUTO_EN
  logic [4:0] unused_round_in_s;
  assign unused_round_in_s = round_in;

  // Internal round counter: advances as DONE is left, wraps after the last
  // round; a clear request wins over the DONE increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r <= 5'd0;
    end else if (round_clr) begin
      addr_r <= 5'd0;
    end else if (state_r == S_DONE) begin
      if (addr_r == LAST_ROUND) begin
        addr_r <= 5'd0;
      end else begin
        addr_r <= addr_r + 5'd1;
      end
    end else begin
      addr_r <= addr_r;
    end
  end
`else
  logic unused_round_clr_s;
  assign unused_round_clr_s = round_clr;

  // Capture the external round index when a pass is accepted and hold it so
  // the LUT address cannot move mid-pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r <= 5'd0;
    end else if ((state_r == S_IDLE) && start) begin
      addr_r <= round_in;
    end else begin
      addr_r <= addr_r;
    end
  end
`endif

  assign ld          = ld_r;
  assign sel_in      = sel_in_r;
  assign counter_rst = counter_rst_r;
  assign write       = write_r;
  assign ready       = ready_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign address     = addr_r;
  // The last slice suppresses the increment so the slice counter stays at 63.
  assign inc_counter = write_r & ~co;
  assign round_last  = done_r & (addr_r == LAST_ROUND);

endmodule

// File: tb/tb_add_rc_ctrl.sv
// Directed testbench for add_rc_ctrl; models the 6-bit slice counter that
// produces co and checks pass timing, address handling and reset abort.
module tb_add_rc_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       co;
  logic [4:0] round_in;
  logic       round_clr;
  logic       ld;
  logic       sel_in;
  logic       inc_counter;
  logic       counter_rst;
  logic       write;
  logic [4:0] address;
  logic       ready;
  logic       busy;
  logic       done;
  logic       round_last;

  logic [5:0] slice_cnt;
  logic       force_co;
  int         vec_cnt;
  int         miss_cnt;

  add_rc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .co          (co),
    .round_in    (round_in),
    .round_clr   (round_clr),
    .ld          (ld),
    .sel_in      (sel_in),
    .inc_counter (inc_counter),
    .counter_rst (counter_rst),
    .write       (write),
    .address     (address),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .round_last  (round_last)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath slice counter model.
  always @(posedge clk) begin
    if (counter_rst) slice_cnt <= 6'd0;
    else if (inc_counter) slice_cnt <= slice_cnt + 6'd1;
  end

  assign co = (slice_cnt == 6'd63) | (force_co & ld);

  task automatic check_vec(input string tag, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One full pass: start sampled in cycle 0, outputs sampled mid-cycle.
  task automatic run_pass(input logic [4:0] rin, input logic [4:0] exp_addr,
                          input logic exp_last, input bit hold, input bit chg_rin,
                          input bit fco, input bit clr_done);
    int n_wr = 0, n_inc = 0, n_done = 0, done_at = -1, cr_at = -1, rdy_at = -1;
    int addr_bad = 0, sel_bad = 0, last_bad = 0;
    @(negedge clk);
    check_vec("idle_ready", ready, 1);
    round_in = rin;
    start    = 1'b1;
    force_co = fco;
    for (int c = 1; c <= 195; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (chg_rin && c == 100) round_in = 5'd3;
      if (write) n_wr++;
      if (inc_counter) n_inc++;
      if (done) begin n_done++; done_at = c; end
      if (counter_rst && cr_at < 0) cr_at = c;
      if (ready && rdy_at < 0) rdy_at = c;
      if (c <= 194 && address != exp_addr) addr_bad++;
      if (sel_in && !ld) sel_bad++;
      if (round_last != (done && exp_last)) last_bad++;
      if (clr_done && c == 194) round_clr = 1'b1;
      if (clr_done && c == 195) begin
        round_clr = 1'b0;
        check_vec("clr_at_done_addr", address, 0);
      end
    end
    force_co = 1'b0;
    check_vec("writes", n_wr, 64);
    check_vec("incs", n_inc, 63);
    check_vec("done_count", n_done, 1);
    check_vec("done_cycle", done_at, 194);
    check_vec("ctr_rst_cycle", cr_at, 1);
    check_vec("ready_cycle", rdy_at, 195);
    check_vec("addr_stable", addr_bad, 0);
    check_vec("sel_in_only_xor", sel_bad, 0);
    check_vec("round_last", last_bad, 0);
    if (hold) begin
      @(negedge clk);
      start = 1'b0;
      check_vec("restart_init", counter_rst, 1);
      check_vec("restart_busy", busy, 1);
      do_reset();
    end
  endtask

  // Reset asserted in cycle 100 of a pass.
  task automatic reset_mid_pass(input logic [4:0] rin);
    int n_wr = 0, n_done = 0, n_inc = 0;
    @(negedge clk);
    round_in = rin;
    start    = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_vec("abort_ready", ready, 1);
    check_vec("abort_busy", busy, 0);
`ifdef ADD_RC_CTRL_ROUND_AUTO_EN
    check_vec("abort_addr", address, 0);
`endif
    for (int c = 101; c <= 260; c++) begin
      if (write) n_wr++;
      if (done) n_done++;
      if (inc_counter) n_inc++;
      @(negedge clk);
    end
    check_vec("abort_no_write", n_wr, 0);
    check_vec("abort_no_done", n_done, 0);
    check_vec("abort_no_inc", n_inc, 0);
  endtask

  initial begin
    vec_cnt   = 0;
    miss_cnt  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    force_co  = 1'b0;
    round_in  = 5'd0;
    round_clr = 1'b0;
    do_reset();
    check_vec("rst_ready", ready, 1);
    check_vec("rst_busy", busy, 0);
    check_vec("rst_done", done, 0);
    check_vec("rst_ld", ld, 0);
    check_vec("rst_sel_in", sel_in, 0);
    check_vec("rst_write", write, 0);
    check_vec("rst_ctr_rst", counter_rst, 0);
    check_vec("rst_inc", inc_counter, 0);
    check_vec("rst_address", address, 0);
    check_vec("rst_round_last", round_last, 0);

`ifdef ADD_RC_CTRL_ROUND_AUTO_EN
    for (int p = 0; p < 24; p++) begin
      run_pass(5'd9, 5'(p), (p == 23), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    run_pass(5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_pass(5'd9, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_pass(5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_pass(5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_mid_pass(5'd9);
`else
    run_pass(5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_pass(5'd17, 5'd17, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_pass(5'd23, 5'd23, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_pass(5'd2, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_pass(5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset_mid_pass(5'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/add_rc_ctrl.md
ADD_RC_CTRL -- requirements
Module: add_rc_ctrl

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset: rst is sampled only on the rising edge of clk.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request one add-round-constant pass over 64 slices; sampled only while ready=1.
REQ-005 co  input  1  slice-counter carry from datapath; high when slice count = 63.
REQ-006 round_in  input  5  external round index 0..23; used only without ADD_RC_CTRL_ROUND_AUTO_EN.
REQ-007 round_clr  input  1  synchronous clear of internal round counter; ignored without the macro.
REQ-008 ld  output  1  datapath register load enable.
REQ-009 sel_in  output  1  datapath mux select: 0 = input slice, 1 = XOR feedback.
REQ-010 inc_counter  output  1  slice-counter increment.
REQ-011 counter_rst  output  1  slice-counter clear.
REQ-012 write  output  1  output-memory write enable.
REQ-013 address  output  5  round-constant LUT address.
REQ-014 ready  output  1  high only in IDLE.
REQ-015 busy  output  1  high in INIT, LOAD, XOR, WRITE.
REQ-016 done  output  1  one-cycle pulse in DONE.
REQ-017 round_last  output  1  high with done when the completed pass used round 23.

Function
REQ-018 FSM states SHALL be IDLE, INIT, LOAD, XOR, WRITE, DONE; all outputs SHALL be Moore-decoded from the state.
REQ-019 IDLE: ready=1, all other strobes 0; start=1 -> INIT, else stay.
REQ-020 INIT: counter_rst=1; always -> LOAD.
REQ-021 LOAD: ld=1, sel_in=0; always -> XOR.
REQ-022 XOR: ld=1, sel_in=1; always -> WRITE.
REQ-023 WRITE: write=1; if co=0 then inc_counter=1 and -> LOAD; if co=1 then inc_counter=0 and -> DONE.
REQ-024 DONE: done=1; always -> IDLE.
REQ-025 co SHALL be ignored in every state except WRITE.
REQ-026 start SHALL be ignored in every state except IDLE; no request is queued.
REQ-027 Each slice SHALL take exactly 3 cycles; with start sampled in cycle 0, INIT occupies cycle 1, slices occupy cycles 2-193, and done is high in cycle 194 only; ready returns in cycle 195.
REQ-028 sel_in SHALL be 0 in all states other than XOR; address SHALL remain stable from INIT through DONE.

Reset
REQ-029 With rst=1 at a clock edge, the FSM SHALL enter IDLE and the round counter SHALL clear to 0, overriding start, co and round_clr.
REQ-030 Reset values: ready=1, address=0 (with the macro), all other outputs 0.
REQ-031 Reset during any busy state SHALL abort the pass without a further write, inc_counter or done.

Configuration
REQ-032 Macro ADD_RC_CTRL_ROUND_AUTO_EN defined: an internal 5-bit round counter drives address, increments by 1 on each DONE cycle, wraps 23 -> 0, and clears on round_clr=1 in any state; when round_clr coincides with DONE, the clear wins.
REQ-033 Macro not defined: address SHALL be round_in, captured into a register when start is accepted in IDLE and held for the pass; round_clr SHALL be ignored.
REQ-034 round_last SHALL equal (address = 23) AND done in both configurations.

Verification
REQ-035 Reset, then start=1 for one cycle, with co modelled from a 6-bit counter -> counter_rst in cycle 1, 64 write pulses, done only in cycle 194, ready again in cycle 195.
REQ-036 start held high across the whole pass -> exactly one pass, and a second pass begins in the cycle after ready returns.
REQ-037 Macro defined, 24 back-to-back passes -> address 0..23 in order, round_last only on pass 24, address=0 on pass 25.
REQ-038 Macro undefined, round_in=17 at start, then round_in changed to 3 mid-pass -> address=17 for the whole pass.
REQ-039 rst=1 in cycle 100 of a pass -> IDLE next cycle, no done pulse, write=0 from that cycle on, address=0 with the macro defined.
REQ-040 co forced high during LOAD and XOR -> no effect; with the macro defined, round_clr coinciding with DONE -> address=0 afterwards.
